// File: rtl/rr_arbiter4.sv
// Round-robin bus arbiter for four masters.
// Picks one owner from the level-held requests and keeps it until the owner
// releases its request or overstays the hold limit while others wait.
// Drives decoder2_4 downstream: Grant_Idx -> Data, Grant_EN -> EN.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   Req[3:0]   per-master request, bit i = master i
//   Grant_Idx  encoded index of the current owner
//   Grant_EN   1 while Grant_Idx owns the bus
//   Timeout    one-cycle pulse on the cycle a preempting grant first appears
//
// Parameters:
//   MAX_HOLD   max consecutive owned cycles while others wait (0 = unlimited)
//   CNT_W      hold-counter width, must be able to hold MAX_HOLD
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Req,
  output logic [1:0] Grant_Idx,
  output logic       Grant_EN,
  output logic       Timeout
);

  // With no limit the counter just saturates at all-ones and never preempts.
  localparam logic [CNT_W-1:0] HoldLim = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // First set request bit starting at last+1, wrapping 3->0; last itself is
  // checked last. Scanning from the farthest offset down lets the nearest win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic [3:0] others;
  logic       owner_req;

  always_comb begin
    others    = Req & ~(4'b0001 << owner_q);
    owner_req = Req[owner_q];

    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Req != 4'b0000) begin
          state_d = StOwned;
          owner_d = rr_pick(Req, last_q);
          last_d  = rr_pick(Req, last_q);
          cnt_d   = CNT_W'(1);
        end
      end
      StOwned: begin
        if (!owner_req) begin
          // Release has priority over preemption.
          if (others != 4'b0000) begin
            owner_d = rr_pick(others, last_q);
            last_d  = rr_pick(others, last_q);
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = StIdle;
          end
        end else if ((MAX_HOLD != 0) && (cnt_q == HoldLim) && (others != 4'b0000)) begin
          owner_d   = rr_pick(others, last_q);
          last_d    = rr_pick(others, last_q);
          cnt_d     = CNT_W'(1);
          timeout_d = 1'b1;
        end else if (cnt_q != HoldLim) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;  // master 0 wins the first search
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Grant_Idx = owner_q;
  assign Grant_EN  = (state_q == StOwned);
  assign Timeout   = timeout_q;

endmodule
